// File: rtl/hex_scan_display_if.sv
// -----------------------------------------------------------------------------
// hex_scan_display_if
//   Write port of the hex scan display. A producer presents a complete display
//   image (digit nibbles, decimal points, blanking mask, leading-zero enable)
//   with i_valid; the display takes it when o_ready is high.
//
//   i_data   4*DIGITS  nibble k = digit k, digit 0 rightmost
//   i_dp     DIGITS    decimal point enable per digit
//   i_blank  DIGITS    force digit dark
//   i_lz_en  1         leading-zero suppression enable
//   i_valid  1         write request
//   o_ready  1         display can accept a write
// -----------------------------------------------------------------------------
interface hex_scan_display_if #(
   parameter int DIGITS = 4
) ();

   logic [4*DIGITS-1:0] i_data;
   logic [DIGITS-1:0]   i_dp;
   logic [DIGITS-1:0]   i_blank;
   logic                i_lz_en;
   logic                i_valid;
   logic                o_ready;

   modport master (
      output i_data, i_dp, i_blank, i_lz_en, i_valid,
      input  o_ready
   );

   modport slave (
      input  i_data, i_dp, i_blank, i_lz_en, i_valid,
      output o_ready
   );

endinterface

// File: rtl/hex_scan_display.sv
// -----------------------------------------------------------------------------
// hex_scan_display
//   Multiplexed N-digit seven-segment hex driver for common-anode displays.
//   A prescaler sets the slot length of each digit; the digit pointer walks
//   0..DIGITS-1 and its wrap back to 0 is the frame boundary. New display
//   images are only swapped in at a frame boundary so a frame never tears.
//   Supports per-digit decimal point and blanking, leading-zero suppression
//   and PWM brightness taken from the top bits of the prescaler.
//
//   clk           system clock
//   rst_n         synchronous reset, active-low
//   wr            write port (slave side of hex_scan_display_if)
//   i_brightness  live duty control; all ones = always on, 0 = dark
//   o_anodes      active-low digit enables, at most one low
//   o_segments    {a,b,c,d,e,f,g,dp}, active-high
// -----------------------------------------------------------------------------
module hex_scan_display #(
   parameter int DIGITS    = 4,
   parameter int CNT_WIDTH = 14,
   parameter int PWM_WIDTH = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   hex_scan_display_if.slave    wr,
   input  logic [PWM_WIDTH-1:0] i_brightness,
   output logic [DIGITS-1:0]    o_anodes,
   output logic [7:0]           o_segments
);

   localparam int POS_WIDTH = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [POS_WIDTH-1:0] POS_LAST = POS_WIDTH'(DIGITS - 1);

   typedef enum logic {
      WR_IDLE,
      WR_PENDING
   } wr_state_t;

   // Seven-segment pattern {a..g} for one hex nibble.
   function automatic logic [6:0] decode(input logic [3:0] nib);
      case (nib)
         4'h0:    return 7'b1111110;
         4'h1:    return 7'b0110000;
         4'h2:    return 7'b1101101;
         4'h3:    return 7'b1111001;
         4'h4:    return 7'b0110011;
         4'h5:    return 7'b1011011;
         4'h6:    return 7'b1011111;
         4'h7:    return 7'b1110000;
         4'h8:    return 7'b1111111;
         4'h9:    return 7'b1111011;
         4'hA:    return 7'b1110111;
         4'hB:    return 7'b0011111;
         4'hC:    return 7'b1001110;
         4'hD:    return 7'b0111101;
         4'hE:    return 7'b1001111;
         default: return 7'b1000111;
      endcase
   endfunction

   // ---------------------------------------------------------------- scan timing
   logic [CNT_WIDTH-1:0] cnt;
   logic [POS_WIDTH-1:0] pos;
   logic                 slot_end;
   logic                 frame_end;

   assign slot_end  = &cnt;
   assign frame_end = slot_end && (pos == POS_LAST);

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values of the others; blocking here would create ordering races.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt <= '0;
         pos <= '0;
      end else begin
         cnt <= cnt + CNT_WIDTH'(1);
         if (slot_end) begin
            pos <= (pos == POS_LAST) ? '0 : pos + POS_WIDTH'(1);
         end
      end
   end

   // ---------------------------------------------------------------- write port
   wr_state_t wr_state;
   wr_state_t wr_state_next;
   logic      take_write;
   logic      apply_write;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_state <= WR_IDLE;
      end else begin
         wr_state <= wr_state_next;
      end
   end

   // A write accepted on the frame-boundary edge itself lands in IDLE->PENDING
   // and is therefore held until the following boundary.
   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves a signal unassigned and no latch is inferred.
   always_comb begin
      wr_state_next = wr_state;
      take_write    = 1'b0;
      apply_write   = 1'b0;
      case (wr_state)
         WR_IDLE: begin
            if (wr.i_valid) begin
               take_write    = 1'b1;
               wr_state_next = WR_PENDING;
            end
         end
         WR_PENDING: begin
            if (frame_end) begin
               apply_write   = 1'b1;
               wr_state_next = WR_IDLE;
            end
         end
         default: wr_state_next = WR_IDLE;
      endcase
   end

   assign wr.o_ready = (wr_state == WR_IDLE);

   logic [4*DIGITS-1:0] pend_data;
   logic [DIGITS-1:0]   pend_dp;
   logic [DIGITS-1:0]   pend_blank;
   logic                pend_lz_en;

   // NOTE: the pending payload has no reset; it is only ever read after a
   // transfer has written it, because wr_state qualifies it.
   always_ff @(posedge clk) begin
      if (take_write) begin
         pend_data  <= wr.i_data;
         pend_dp    <= wr.i_dp;
         pend_blank <= wr.i_blank;
         pend_lz_en <= wr.i_lz_en;
      end
   end

   logic [4*DIGITS-1:0] disp_data;
   logic [DIGITS-1:0]   disp_dp;
   logic [DIGITS-1:0]   disp_blank;
   logic                disp_lz_en;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         disp_data  <= '0;
         disp_dp    <= '0;
         disp_blank <= '1;
         disp_lz_en <= 1'b0;
      end else if (apply_write) begin
         disp_data  <= pend_data;
         disp_dp    <= pend_dp;
         disp_blank <= pend_blank;
         disp_lz_en <= pend_lz_en;
      end
   end

   // ---------------------------------------------------------------- digit select
   logic [DIGITS-1:0] supp;
   logic              zero_above;
   logic [3:0]        cur_nib;
   logic              cur_dp;
   logic              cur_blank;
   logic              cur_supp;

   always_comb begin
      supp       = '0;
      zero_above = 1'b1;
      cur_nib    = 4'h0;
      cur_dp     = 1'b0;
      cur_blank  = 1'b0;
      cur_supp   = 1'b0;
      // Walk down from the most significant digit; a digit is a leading zero
      // while it and everything above it are zero. Digit 0 is always shown.
      for (int k = DIGITS - 1; k >= 1; k--) begin
         zero_above = zero_above & (disp_data[4*k +: 4] == 4'h0);
         supp[k]    = disp_lz_en & zero_above;
      end
      for (int k = 0; k < DIGITS; k++) begin
         if (pos == POS_WIDTH'(k)) begin
            cur_nib   = disp_data[4*k +: 4];
            cur_dp    = disp_dp[k];
            cur_blank = disp_blank[k];
            cur_supp  = supp[k];
         end
      end
   end

   // PWM compares the top prescaler bits against the duty; all ones bypasses
   // the compare so full brightness really is 100%.
   logic [PWM_WIDTH-1:0] pwm_phase;
   logic                 pwm_on;
   logic                 digit_on;

   assign pwm_phase = cnt[CNT_WIDTH-1 -: PWM_WIDTH];
   assign pwm_on    = (&i_brightness) | (pwm_phase < i_brightness);
   // A suppressed digit only lights when it still has a decimal point to show.
   assign digit_on  = pwm_on & ~cur_blank & ~(cur_supp & ~cur_dp);

   // ---------------------------------------------------------------- outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         o_anodes   <= '1;
         o_segments <= '0;
      end else if (digit_on) begin
         o_anodes   <= ~(DIGITS'(1) << pos);
         o_segments <= {(cur_supp ? 7'b0000000 : decode(cur_nib)), cur_dp};
      end else begin
         o_anodes   <= '1;
         o_segments <= '0;
      end
   end

endmodule

// File: tb/tb_hex_scan_display.sv
// -----------------------------------------------------------------------------
// tb_hex_scan_display
//   Bench for hex_scan_display. Instance u_dut3 (DIGITS=3, CNT_WIDTH=4,
//   PWM_WIDTH=2) runs the vector table and the hold/reset sequence; instance
//   u_dut5 (DIGITS=5, CNT_WIDTH=3) checks the scan order and a write that
//   coincides with the frame boundary.
// -----------------------------------------------------------------------------
module tb_hex_scan_display;

   localparam int FRAME3 = 48;   // 3 digits * 16 cycles
   localparam int SLOT3  = 16;
   localparam int SLOT5  = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [1:0] bright3;
   logic [1:0] bright5;
   logic [2:0] anodes3;
   logic [7:0] segs3;
   logic [4:0] anodes5;
   logic [7:0] segs5;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hex_scan_display_if #(.DIGITS(3)) bus3 ();
   hex_scan_display_if #(.DIGITS(5)) bus5 ();

   hex_scan_display #(.DIGITS(3), .CNT_WIDTH(4), .PWM_WIDTH(2)) u_dut3 (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr           (bus3.slave),
      .i_brightness (bright3),
      .o_anodes     (anodes3),
      .o_segments   (segs3)
   );

   hex_scan_display #(.DIGITS(5), .CNT_WIDTH(3), .PWM_WIDTH(2)) u_dut5 (
      .clk          (clk),
      .rst_n        (rst_n),
      .wr           (bus5.slave),
      .i_brightness (bright5),
      .o_anodes     (anodes5),
      .o_segments   (segs5)
   );

   typedef struct packed {
      logic [11:0]     data;
      logic [2:0]      dp;
      logic [2:0]      blank;
      logic            lz;
      logic [1:0]      bright;
      logic [2:0][7:0] seg;   // expected segments per digit when lit
      logic [2:0][4:0] lit;   // expected lit cycles per digit in one frame
   } vec_t;

   vec_t vecs [12];
   vec_t exp_q [$];

   function automatic vec_t mk(input logic [11:0] data, input logic [2:0] dp,
                               input logic [2:0] blank, input logic lz,
                               input logic [1:0] br, input logic [7:0] s2,
                               input logic [7:0] s1, input logic [7:0] s0,
                               input logic [4:0] l2, input logic [4:0] l1,
                               input logic [4:0] l0);
      vec_t v;
      v.data   = data;
      v.dp     = dp;
      v.blank  = blank;
      v.lz     = lz;
      v.bright = br;
      v.seg    = {s2, s1, s0};
      v.lit    = {l2, l1, l0};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Polls on falling edges until o_ready is back; ends on the first falling
   // edge after the frame boundary that applied the write.
   task automatic wait_ready3();
      int n = 0;
      while (bus3.o_ready !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("o_ready_return", {31'b0, bus3.o_ready}, 32'd1);
   endtask

   task automatic write3(input vec_t v, input bit track);
      @(negedge clk);
      bus3.i_data  = v.data;
      bus3.i_dp    = v.dp;
      bus3.i_blank = v.blank;
      bus3.i_lz_en = v.lz;
      bus3.i_valid = 1'b1;
      bright3      = v.bright;
      @(posedge clk);
      #1;
      bus3.i_valid = 1'b0;
      check("o_ready_drop", {31'b0, bus3.o_ready}, 32'd0);
      if (track) exp_q.push_back(v);
   endtask

   // Sample i reflects slot position i/16 and prescaler value i%16 of the frame.
   task automatic observe3(input vec_t v, input int first, input int count, input bit full);
      int lit [3];
      for (int d = 0; d < 3; d++) lit[d] = 0;
      for (int i = first; i < first + count; i++) begin
         int d;
         logic [2:0] exp_an;
         @(posedge clk);
         #1;
         d = (i / SLOT3) % 3;
         exp_an = ~(3'b001 << d);
         if (anodes3 === 3'b111) begin
            check("dark_segments", {24'b0, segs3}, 32'h0);
         end else begin
            check("anode_slot", {29'b0, anodes3}, {29'b0, exp_an});
            check("segments", {24'b0, segs3}, {24'b0, v.seg[d]});
            lit[d]++;
         end
      end
      if (full) begin
         check("lit_digit0", lit[0], {27'b0, v.lit[0]});
         check("lit_digit1", lit[1], {27'b0, v.lit[1]});
         check("lit_digit2", lit[2], {27'b0, v.lit[2]});
      end
   endtask

   task automatic observe_frame3();
      vec_t v;
      if (exp_q.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
      end else begin
         v = exp_q.pop_front();
         observe3(v, 0, FRAME3, 1'b1);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t a;
      vec_t b;
      logic [7:0] seg5 [5];

      // {data, dp, blank, lz, bright, seg d2/d1/d0, lit d2/d1/d0}
      vecs[0]  = mk(12'h1A5, 3'b000, 3'b000, 1'b0, 2'b11, 8'b01100000, 8'b11101110, 8'b10110110, 16, 16, 16);
      vecs[1]  = mk(12'h005, 3'b010, 3'b000, 1'b1, 2'b11, 8'b00000000, 8'b00000001, 8'b10110110, 0, 16, 16);
      vecs[2]  = mk(12'h1A5, 3'b000, 3'b000, 1'b0, 2'b01, 8'b01100000, 8'b11101110, 8'b10110110, 4, 4, 4);
      vecs[3]  = mk(12'h1A5, 3'b000, 3'b000, 1'b0, 2'b00, 8'b01100000, 8'b11101110, 8'b10110110, 0, 0, 0);
      vecs[4]  = mk(12'h3C7, 3'b000, 3'b010, 1'b0, 2'b10, 8'b11110010, 8'b00000000, 8'b11100000, 8, 0, 8);
      vecs[5]  = mk(12'h8E0, 3'b111, 3'b000, 1'b1, 2'b11, 8'b11111111, 8'b10011111, 8'b11111101, 16, 16, 16);
      vecs[6]  = mk(12'h000, 3'b000, 3'b000, 1'b1, 2'b11, 8'b00000000, 8'b00000000, 8'b11111100, 0, 0, 16);
      vecs[7]  = mk(12'h0B0, 3'b001, 3'b000, 1'b1, 2'b11, 8'b00000000, 8'b00111110, 8'b11111101, 0, 16, 16);
      vecs[8]  = mk(12'hCDF, 3'b000, 3'b000, 1'b0, 2'b11, 8'b10011100, 8'b01111010, 8'b10001110, 16, 16, 16);
      vecs[9]  = mk(12'h246, 3'b000, 3'b000, 1'b0, 2'b11, 8'b11011010, 8'b01100110, 8'b10111110, 16, 16, 16);
      vecs[10] = mk(12'h090, 3'b000, 3'b000, 1'b0, 2'b11, 8'b11111100, 8'b11110110, 8'b11111100, 16, 16, 16);
      vecs[11] = mk(12'h005, 3'b100, 3'b000, 1'b1, 2'b11, 8'b00000001, 8'b00000000, 8'b10110110, 16, 0, 16);

      seg5[0] = 8'b10110110;   // 5
      seg5[1] = 8'b01100110;   // 4
      seg5[2] = 8'b11110010;   // 3
      seg5[3] = 8'b11011010;   // 2
      seg5[4] = 8'b01100000;   // 1

      rst_n        = 1'b0;
      bright3      = 2'b00;
      bright5      = 2'b00;
      bus3.i_data  = '0;
      bus3.i_dp    = '0;
      bus3.i_blank = '0;
      bus3.i_lz_en = 1'b0;
      bus3.i_valid = 1'b0;
      bus5.i_data  = '0;
      bus5.i_dp    = '0;
      bus5.i_blank = '0;
      bus5.i_lz_en = 1'b0;
      bus5.i_valid = 1'b0;

      // ---- reset and idle
      repeat (2) @(posedge clk);
      #1;
      check("reset_anodes", {29'b0, anodes3}, 32'h7);
      check("reset_segments", {24'b0, segs3}, 32'h0);
      check("reset_ready", {31'b0, bus3.o_ready}, 32'd1);
      @(negedge clk);
      rst_n   = 1'b1;
      bright3 = 2'b11;
      for (int i = 0; i < 200; i++) begin
         @(posedge clk);
         #1;
         check("idle_anodes", {29'b0, anodes3}, 32'h7);
         check("idle_segments", {24'b0, segs3}, 32'h0);
         check("idle_ready", {31'b0, bus3.o_ready}, 32'd1);
      end

      // ---- vector table
      for (int n = 0; n < 12; n++) begin
         write3(vecs[n], 1'b1);
         wait_ready3();
         observe_frame3();
      end

      // ---- writes while pending are ignored
      a = vecs[0];
      b = vecs[9];
      write3(a, 1'b1);
      @(negedge clk);
      bus3.i_data  = 12'h777;
      bus3.i_dp    = 3'b111;
      bus3.i_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("held_ready_low", {31'b0, bus3.o_ready}, 32'd0);
      end
      bus3.i_valid = 1'b0;
      wait_ready3();
      observe_frame3();

      // ---- new write mid-frame leaves the current image alone, then reset
      write3(b, 1'b0);
      observe3(a, 1, 20, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("midreset_anodes", {29'b0, anodes3}, 32'h7);
      check("midreset_segments", {24'b0, segs3}, 32'h0);
      check("midreset_ready", {31'b0, bus3.o_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 2 * FRAME3 + 4; i++) begin
         @(posedge clk);
         #1;
         check("post_reset_dark", {29'b0, anodes3}, 32'h7);
         check("post_reset_ready", {31'b0, bus3.o_ready}, 32'd1);
      end

      // ---- 5-digit instance: write on the frame-boundary edge
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (39) @(posedge clk);
      @(negedge clk);
      bus5.i_data  = 20'h12345;
      bus5.i_dp    = 5'b00000;
      bus5.i_blank = 5'b00000;
      bus5.i_lz_en = 1'b0;
      bus5.i_valid = 1'b1;
      bright5      = 2'b11;
      @(posedge clk);              // edge 40: frame boundary
      #1;
      bus5.i_valid = 1'b0;
      check("fb_write_ready_drop", {31'b0, bus5.o_ready}, 32'd0);
      repeat (39) @(posedge clk);  // edge 79
      #1;
      check("fb_write_still_pending", {31'b0, bus5.o_ready}, 32'd0);
      check("fb_write_still_dark", {27'b0, anodes5}, 32'h1F);
      @(posedge clk);              // edge 80: next frame boundary
      #1;
      check("fb_write_applied_ready", {31'b0, bus5.o_ready}, 32'd1);
      check("fb_write_last_old_slot", {27'b0, anodes5}, 32'h1F);
      for (int i = 0; i < 48; i++) begin
         int d;
         @(posedge clk);
         #1;
         d = (i / SLOT5) % 5;
         check("scan5_anodes", {27'b0, anodes5}, {27'b0, ~(5'b00001 << d)});
         check("scan5_segments", {24'b0, segs5}, {24'b0, seg5[d]});
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
